vendo_coin_acceptor: RTL and testbench



---
 rtl/vendo_pkg.sv | 25 ++
 rtl/vendo_debounce.sv | 50 +++++
 rtl/vendo_coin_acceptor.sv | 113 +++++++++++
 tb/tb_vendo_coin_acceptor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vendo_pkg.sv
// Shared definitions for the 2P vending front end: coin-acceptor FSM states, coin pulse codes
// and the vending-machine credit states. Both the acceptor and the vending FSM import this
// package, so the encodings have a single source.
package vendo_pkg;

   // Coin-acceptor frame states; 2'b11 is illegal and recovers to StIdle.
   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StCount  = 2'b01,
      StDecide = 2'b10
   } acc_state_e;

   // Validator pulse counts that identify each coin.
   localparam int unsigned CoinP1Pulses = 1;
   localparam int unsigned CoinP5Pulses = 5;

   // Credit states of the 2-peso vending machine FSM that consumes p1/p5.
   typedef enum logic [1:0] {
      VmIdle     = 2'b00,
      VmOnePeso  = 2'b01,
      VmDispense = 2'b10,
      VmChange   = 2'b11
   } vm_state_e;

endpackage

// File: rtl/vendo_debounce.sv
// Input conditioning for the coin validator line: 2-flop synchroniser, debouncer and
// rising-edge detector.
//   clk, reset : clock and asynchronous active-low reset
//   din        : raw asynchronous input
//   level      : debounced level
//   rise       : one-cycle strobe, high in the cycle right after level goes 0->1
module vendo_debounce #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CntW-1:0] DebLast = CntW'(DEB_CYCLES - 1);

   logic            sync1_q;
   logic            sync2_q;
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level   <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         rise    <= 1'b0;
         if (sync2_q != level) begin
            // This is the DEB_CYCLES-th consecutive disagreeing sample: accept the new level.
            if (cnt_q == DebLast) begin
               level <= sync2_q;
               rise  <= sync2_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + CntW'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/vendo_coin_acceptor.sv
// Coin acceptor: turns the validator pulse train into one p1/p5/reject strobe per coin frame.
// A frame opens on the first debounced rise, counts rises, closes after GAP_CYCLES idle
// cycles and is judged in a single DECIDE cycle.
//   clk, reset : clock and asynchronous active-low reset
//   coin_in    : raw validator pulse line (asynchronous, may bounce)
//   accept_en  : host permits crediting, sampled in the DECIDE cycle only
//   p1, p5     : one-cycle strobes for a credited 1-peso / 5-peso coin
//   reject     : one-cycle strobe for a frame that is not credited
//   busy       : high while a frame is open (COUNT or DECIDE)
//   cstate     : current FSM state for debug
module vendo_coin_acceptor
   import vendo_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned P1_PULSES  = CoinP1Pulses,
   parameter int unsigned P5_PULSES  = CoinP5Pulses
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_in,
   input  logic       accept_en,
   output logic       p1,
   output logic       p5,
   output logic       reject,
   output logic       busy,
   output logic [1:0] cstate
);

   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

   logic            level;
   logic            rise;
   acc_state_e      state_q;
   logic [2:0]      count_q;
   logic [GapW-1:0] gap_q;
   logic            credit_ok;

   vendo_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .din   (coin_in),
      .level (level),
      .rise  (rise)
   );

   // A coin is only credited once the line has returned low; a stuck-high line is rejected.
   assign credit_ok = accept_en & ~level;
   assign cstate    = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         count_q <= 3'd0;
         gap_q   <= '0;
         p1      <= 1'b0;
         p5      <= 1'b0;
         reject  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         p1     <= 1'b0;
         p5     <= 1'b0;
         reject <= 1'b0;
         case (state_q)
            StIdle: begin
               if (rise) begin
                  count_q <= 3'd1;
                  gap_q   <= '0;
                  state_q <= StCount;
                  busy    <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end
            StCount: begin
               busy <= 1'b1;
               // A rise coinciding with the timeout is counted and keeps the frame open.
               if (rise) begin
                  if (count_q != 3'd7) begin
                     count_q <= count_q + 3'd1;
                  end
                  gap_q <= '0;
               end else if (gap_q == GapLast) begin
                  state_q <= StDecide;
               end else begin
                  gap_q <= gap_q + GapW'(1);
               end
            end
            StDecide: begin
               // Rises seen here are dropped; the next coin starts from IDLE.
               busy    <= 1'b0;
               state_q <= StIdle;
               gap_q   <= '0;
               if (credit_ok && (count_q == 3'(P1_PULSES))) begin
                  p1 <= 1'b1;
               end else if (credit_ok && (count_q == 3'(P5_PULSES))) begin
                  p5 <= 1'b1;
               end else begin
                  reject <= 1'b1;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vendo_coin_acceptor.sv
// Self-checking bench for vendo_coin_acceptor. Inputs change on the falling edge; outputs are
// compared on the falling edge against a cycle model built from the coin-frame rules.
module tb_vendo_coin_acceptor;

   localparam int DEB = 4;
   localparam int GAP = 16;
   localparam int P1N = 1;
   localparam int P5N = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_in;
   logic       accept_en;
   logic       p1;
   logic       p5;
   logic       reject;
   logic       busy;
   logic [1:0] cstate;

   vendo_coin_acceptor #(
      .DEB_CYCLES (DEB),
      .GAP_CYCLES (GAP),
      .P1_PULSES  (P1N),
      .P5_PULSES  (P5N)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .coin_in   (coin_in),
      .accept_en (accept_en),
      .p1        (p1),
      .p5        (p5),
      .reject    (reject),
      .busy      (busy),
      .cstate    (cstate)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   // Reference model state.
   logic hist[$];       // samples of coin_in taken at recent clock edges, newest last
   logic lvl_m;         // debounced level
   logic rise_pend_m;   // debounced rise waiting to be seen by the frame logic
   bit   open_m;        // coin frame open (COUNT or DECIDE)
   int   cnt_m;
   int   last_cap_m;    // edge at which the newest pulse was counted
   int   exp_p1, exp_p5, exp_rej, exp_busy, exp_state;

   // Strobe bookkeeping for the directed tests.
   int   p1_seen, p5_seen, rej_seen, strobe_edge;

   typedef struct {
      int pulses;
      int hi;
      int lo;
      bit en;
      int kind;   // 1 = p1, 2 = p5, 3 = reject
   } vec_t;

   vec_t vecs[9];
   int   bounce[];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
      lvl_m       = 1'b0;
      rise_pend_m = 1'b0;
      open_m      = 1'b0;
      cnt_m       = 0;
      last_cap_m  = 0;
      exp_p1      = 0;
      exp_p5      = 0;
      exp_rej     = 0;
      exp_busy    = 0;
      exp_state   = 0;
   endtask

   // Advance the model over clock edge edge_n, where c and en are the sampled inputs.
   task automatic model_edge(input logic c, input logic en);
      bit flip;
      exp_p1  = 0;
      exp_p5  = 0;
      exp_rej = 0;
      // Frame closes GAP edges after its last counted pulse; one edge later it is judged.
      if (open_m && edge_n == last_cap_m + GAP + 1) begin
         open_m = 0;
         if (en && !lvl_m && cnt_m == P1N)      exp_p1 = 1;
         else if (en && !lvl_m && cnt_m == P5N) exp_p5 = 1;
         else                                   exp_rej = 1;
      end else if (rise_pend_m) begin
         cnt_m      = open_m ? ((cnt_m + 1 > 7) ? 7 : cnt_m + 1) : 1;
         open_m     = 1;
         last_cap_m = edge_n;
      end
      // The synchronised stream lags the raw samples by two edges; the level flips once the
      // last DEB synchronised samples all disagree with it.
      flip = 1;
      for (int j = 0; j < DEB; j++) begin
         if (hist[hist.size() - 2 - j] == lvl_m) flip = 0;
      end
      rise_pend_m = flip && !lvl_m;
      if (flip) lvl_m = !lvl_m;
      hist.push_back(c);
      if (hist.size() > DEB + 2) void'(hist.pop_front());
      exp_busy  = open_m ? 1 : 0;
      exp_state = !open_m ? 0 : ((edge_n == last_cap_m + GAP) ? 2 : 1);
   endtask

   // One clock cycle: drive coin_in, clock it in, then compare every output.
   task automatic step(input logic c);
      coin_in = c;
      @(posedge clk);
      edge_n++;
      model_edge(c, accept_en);
      @(negedge clk);
      chk("p1", int'(p1), exp_p1);
      chk("p5", int'(p5), exp_p5);
      chk("reject", int'(reject), exp_rej);
      chk("busy", int'(busy), exp_busy);
      chk("cstate", int'(cstate), exp_state);
      chk("exclusive", ((int'(p1) + int'(p5) + int'(reject)) <= 1) ? 1 : 0, 1);
      if (p1) p1_seen++;
      if (p5) p5_seen++;
      if (reject) rej_seen++;
      if (p1 || p5 || reject) strobe_edge = edge_n;
   endtask

   task automatic clear_seen();
      p1_seen     = 0;
      p5_seen     = 0;
      rej_seen    = 0;
      strobe_edge = -1;
   endtask

   task automatic pulse(input int hi, input int lo);
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
   endtask

   initial begin
      int m;
      int val, run;

      vecs[0] = '{1, 10, 8, 1'b1, 1};
      vecs[1] = '{5, 8, 8, 1'b1, 2};
      vecs[2] = '{3, 8, 8, 1'b1, 3};
      vecs[3] = '{1, 10, 8, 1'b0, 3};
      vecs[4] = '{1, 40, 8, 1'b1, 3};
      vecs[5] = '{8, 6, 6, 1'b1, 3};
      vecs[6] = '{5, 8, 8, 1'b0, 3};
      vecs[7] = '{2, 6, 10, 1'b1, 3};
      vecs[8] = '{5, 5, 11, 1'b1, 2};
      bounce  = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 1};

      reset     = 1'b0;
      coin_in   = 1'b0;
      accept_en = 1'b0;
      model_reset();
      clear_seen();
      #3;
      chk("rst_p1", int'(p1), 0);
      chk("rst_p5", int'(p5), 0);
      chk("rst_reject", int'(reject), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cstate", int'(cstate), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) step(1'b0);

      // Table-driven coin frames: strobe kind, count and latency from the last raw rise.
      for (int v = 0; v < 9; v++) begin
         clear_seen();
         accept_en = vecs[v].en;
         m = 0;
         for (int p = 0; p < vecs[v].pulses; p++) begin
            m = edge_n + 1;
            pulse(vecs[v].hi, vecs[v].lo);
         end
         repeat (30) step(1'b0);
         chk($sformatf("vec%0d_p1", v), p1_seen, (vecs[v].kind == 1) ? 1 : 0);
         chk($sformatf("vec%0d_p5", v), p5_seen, (vecs[v].kind == 2) ? 1 : 0);
         chk($sformatf("vec%0d_reject", v), rej_seen, (vecs[v].kind == 3) ? 1 : 0);
         chk($sformatf("vec%0d_latency", v), strobe_edge - m, DEB + GAP + 3);
      end

      // Bouncy single pulse: glitches on both edges must not add pulses.
      clear_seen();
      accept_en = 1'b1;
      foreach (bounce[i]) step(bounce[i] != 0);
      repeat (30) step(1'b0);
      chk("bounce_p1", p1_seen, 1);
      chk("bounce_reject", rej_seen + p5_seen, 0);

      // Reset in the middle of a three-pulse frame drops it without any strobe.
      clear_seen();
      repeat (3) pulse(8, 8);
      reset = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_cstate", int'(cstate), 0);
      chk("midrst_strobes", int'(p1) + int'(p5) + int'(reject), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      repeat (30) step(1'b0);
      chk("aborted_frame", p1_seen + p5_seen + rej_seen, 0);
      pulse(10, 8);
      repeat (30) step(1'b0);
      chk("after_rst_p1", p1_seen, 1);
      chk("after_rst_other", p5_seen + rej_seen, 0);

      // Random runs of levels (including bounces) and random accept_en.
      for (int r = 0; r < 300; r++) begin
         val       = $urandom_range(0, 1);
         run       = $urandom_range(1, 12);
         accept_en = ($urandom_range(0, 3) != 0);
         repeat (run) step(val != 0);
      end
      repeat (40) step(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
